// File: rtl/pipeline_control_unit_pkg.sv
// Shared types and constants for the pipeline control unit and its neighbours
// (forwarding unit, datapath latches).
package pipeline_control_unit_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pcu_state_t;

    typedef logic [4:0] regbits_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ORI   = 6'h0d,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b,
        OP_HALT  = 6'h3f
    } opcode_t;

    // Writeback select value meaning "result comes from data memory".
    localparam logic [1:0] REGSEL_DMEM = 2'b11;

    typedef struct packed {
        logic pc_en;
        logic en_fd;
        logic en_de;
        logic en_em;
        logic en_mw;
        logic flush_fd;
        logic flush_de;
    } pcu_ctl_t;

    localparam pcu_ctl_t CTL_FREEZE  = 7'b0000000;
    localparam pcu_ctl_t CTL_FLOW    = 7'b1111100;
    localparam pcu_ctl_t CTL_BUBBLE  = 7'b0011101;
    localparam pcu_ctl_t CTL_SQUASH  = 7'b1111111;
    localparam pcu_ctl_t CTL_FETCHWT = 7'b0111110;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Hazard inputs from the pipeline and latch/PC control outputs of the
// pipeline control unit.
interface pipeline_control_unit_if
    import pipeline_control_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             dREN_me;
    logic             dWEN_me;
    logic             halt_me;
    opcode_t          opcode_de;
    regbits_t         rs_de;
    regbits_t         rt_de;
    logic             uses_rt_de;
    regbits_t         regDst_ex;
    logic             regWr_ex;
    logic [1:0]       regSel_ex;
    logic             branch_taken_ex;
    logic             jump_de;

    logic             pc_en;
    logic             en_fd;
    logic             en_de;
    logic             en_em;
    logic             en_mw;
    logic             flush_fd;
    logic             flush_de;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    modport pcu (
        input  ihit, dhit, dREN_me, dWEN_me, halt_me, opcode_de, rs_de, rt_de,
               uses_rt_de, regDst_ex, regWr_ex, regSel_ex, branch_taken_ex, jump_de,
        output pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, halt, stall_cnt
    );

    modport tb (
        output ihit, dhit, dREN_me, dWEN_me, halt_me, opcode_de, rs_de, rt_de,
               uses_rt_de, regDst_ex, regWr_ex, regSel_ex, branch_taken_ex, jump_de,
        input  pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, halt, stall_cnt
    );

endinterface

// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: latch enables, bubbles and PC enable for the 5-stage core,
// covering load-use, cache waits, redirects and halt drain.
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    pipeline_control_unit_if.pcu     pif
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    pcu_state_t       state_q, state_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             halt_q, halt_d;

    pcu_ctl_t         ctl;
    logic             mem_miss;
    logic             dwait;
    logic             load_use;
    logic             stall_inc;
    logic             unused_opcode;

    // JR reads rs, so it is caught by the rs compare without special casing.
    function automatic logic detect_load_use(
        input logic       wr_ex,
        input logic [1:0] sel_ex,
        input regbits_t   dst_ex,
        input regbits_t   rs,
        input regbits_t   rt,
        input logic       uses_rt
    );
        logic is_load;
        is_load = wr_ex && (sel_ex == REGSEL_DMEM) && (dst_ex != '0);
        return is_load && ((rs == dst_ex) || (uses_rt && (rt == dst_ex)));
    endfunction

    // Register usage is pre-decoded upstream into uses_rt_de/jump_de.
    assign unused_opcode = ^pif.opcode_de;

    assign mem_miss = (pif.dREN_me | pif.dWEN_me) & ~pif.dhit;
    // The hit cycle itself completes the access, so the pipeline advances then.
    assign dwait    = ((state_q == DWAIT) & ~pif.dhit) | ((state_q == RUN) & mem_miss);
    assign load_use = detect_load_use(pif.regWr_ex, pif.regSel_ex, pif.regDst_ex,
                                      pif.rs_de, pif.rt_de, pif.uses_rt_de);

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        halt_d      = halt_q;
        case (state_q)
            RUN: begin
                if (mem_miss) begin
                    state_d = DWAIT;
                end else if (pif.halt_me) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DWAIT: begin
                if (pif.dhit) state_d = RUN;
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        ctl = CTL_FREEZE;
        if (!nRST || state_q == HALTED || dwait) begin
            ctl = CTL_FREEZE;
        end else if (state_q == DRAIN) begin
            ctl = CTL_BUBBLE;
        end else if (pif.branch_taken_ex) begin
            ctl = CTL_SQUASH;
        end else if (load_use) begin
            ctl = CTL_BUBBLE;
        end else if (pif.jump_de) begin
            ctl          = CTL_FLOW;
            ctl.pc_en    = pif.ihit;
            ctl.flush_fd = 1'b1;
        end else if (!pif.ihit) begin
            ctl = CTL_FETCHWT;
        end else begin
            ctl = CTL_FLOW;
        end
    end

    assign stall_inc = ~ctl.pc_en & ((state_q == RUN) | (state_q == DWAIT));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            halt_q      <= halt_d;
        end
    end

    assign pif.pc_en     = ctl.pc_en;
    assign pif.en_fd     = ctl.en_fd;
    assign pif.en_de     = ctl.en_de;
    assign pif.en_em     = ctl.en_em;
    assign pif.en_mw     = ctl.en_mw;
    assign pif.flush_fd  = ctl.flush_fd;
    assign pif.flush_de  = ctl.flush_de;
    assign pif.halt      = halt_q;
    assign pif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: directed hazard scenarios with
// expected control words queued at drive time and compared mid-cycle.
module tb_pipeline_control_unit;
    import pipeline_control_unit_pkg::*;

    localparam int unsigned CNT_W        = 4;
    localparam int unsigned DRAIN_CYCLES = 2;

    // {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de}
    localparam logic [6:0] E_OFF  = 7'b0000000;
    localparam logic [6:0] E_RUN  = 7'b1111100;
    localparam logic [6:0] E_HOLD = 7'b0011101;
    localparam logic [6:0] E_BR   = 7'b1111111;
    localparam logic [6:0] E_JMP  = 7'b1111110;
    localparam logic [6:0] E_MISS = 7'b0111110;

    typedef struct {
        string      tag;
        logic [6:0] ctl;
        logic       halt;
        int         cnt;
    } exp_t;

    logic CLK;
    logic nRST;
    exp_t sb[$];
    int   n_vec;
    int   n_err;

    pipeline_control_unit_if #(.CNT_W(CNT_W)) pif ();

    pipeline_control_unit #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .pif  (pif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [6:0] obs;
            e   = sb.pop_front();
            obs = {pif.pc_en, pif.en_fd, pif.en_de, pif.en_em, pif.en_mw,
                   pif.flush_fd, pif.flush_de};
            check({e.tag, "_ctl"}, 32'(obs), 32'(e.ctl));
            check({e.tag, "_halt"}, 32'(pif.halt), 32'(e.halt));
            check({e.tag, "_cnt"}, 32'(pif.stall_cnt), 32'(e.cnt));
        end
    end

    task automatic set_idle();
        pif.ihit            = 1'b1;
        pif.dhit            = 1'b0;
        pif.dREN_me         = 1'b0;
        pif.dWEN_me         = 1'b0;
        pif.halt_me         = 1'b0;
        pif.opcode_de       = OP_RTYPE;
        pif.rs_de           = 5'd0;
        pif.rt_de           = 5'd0;
        pif.uses_rt_de      = 1'b0;
        pif.regDst_ex       = 5'd0;
        pif.regWr_ex        = 1'b0;
        pif.regSel_ex       = 2'b00;
        pif.branch_taken_ex = 1'b0;
        pif.jump_de         = 1'b0;
    endtask

    task automatic step(input string tag, input logic [6:0] ctl, input logic h, input int cnt);
        exp_t e;
        e.tag  = tag;
        e.ctl  = ctl;
        e.halt = h;
        e.cnt  = cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lw(input logic [4:0] dst);
        pif.opcode_de = OP_ADDI;
        pif.regWr_ex  = 1'b1;
        pif.regSel_ex = REGSEL_DMEM;
        pif.regDst_ex = dst;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        set_idle();
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        step("rst", E_OFF, 1'b0, 0);
        nRST = 1'b1;
        step("run0", E_RUN, 1'b0, 0);

        set_lw(5'd2); pif.rs_de = 5'd2;
        step("lu_rs", E_HOLD, 1'b0, 0);
        set_idle();
        step("lu_after", E_RUN, 1'b0, 1);
        set_lw(5'd0); pif.rs_de = 5'd0;
        step("lu_r0", E_RUN, 1'b0, 1);
        set_idle(); set_lw(5'd5); pif.rs_de = 5'd1; pif.rt_de = 5'd5; pif.uses_rt_de = 1'b1;
        step("lu_rt", E_HOLD, 1'b0, 1);
        pif.uses_rt_de = 1'b0;
        step("lu_rt_unused", E_RUN, 1'b0, 2);
        pif.uses_rt_de = 1'b1; pif.regSel_ex = 2'b01;
        step("not_load", E_RUN, 1'b0, 2);
        pif.regSel_ex = REGSEL_DMEM; pif.regWr_ex = 1'b0;
        step("no_wr", E_RUN, 1'b0, 2);

        set_idle(); pif.dREN_me = 1'b1;
        step("dw1", E_OFF, 1'b0, 2);
        pif.ihit = 1'b0;
        step("dw2", E_OFF, 1'b0, 3);
        pif.ihit = 1'b1;
        step("dw3", E_OFF, 1'b0, 4);
        pif.dhit = 1'b1;
        step("dw_hit", E_RUN, 1'b0, 5);
        set_idle(); pif.ihit = 1'b0;
        step("dw_back_run", E_MISS, 1'b0, 5);
        set_idle();
        step("dw_idle", E_RUN, 1'b0, 6);

        set_lw(5'd4); pif.rs_de = 5'd4; pif.ihit = 1'b0; pif.branch_taken_ex = 1'b1;
        step("br_over_lu", E_BR, 1'b0, 6);
        set_idle();
        step("br_after", E_RUN, 1'b0, 6);
        pif.jump_de = 1'b1; pif.opcode_de = OP_J;
        step("jmp_hit", E_JMP, 1'b0, 6);
        pif.ihit = 1'b0;
        step("jmp_miss", E_MISS, 1'b0, 6);
        set_idle(); pif.jump_de = 1'b1; set_lw(5'd9); pif.rs_de = 5'd9;
        step("jr_lu", E_HOLD, 1'b0, 7);
        set_idle(); pif.ihit = 1'b0;
        step("fetch_wait", E_MISS, 1'b0, 8);
        set_idle(); pif.dWEN_me = 1'b1; pif.dhit = 1'b1;
        step("sw_hit", E_RUN, 1'b0, 9);
        pif.dhit = 1'b0;
        step("sw_miss", E_OFF, 1'b0, 9);
        step("sw_dwait", E_OFF, 1'b0, 10);
        nRST = 1'b0;
        step("rst_dwait", E_OFF, 1'b0, 0);
        nRST = 1'b1; set_idle();
        step("post_rst", E_RUN, 1'b0, 0);

        pif.ihit = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step("sat", E_MISS, 1'b0, (i > 15) ? 15 : i);
        end
        pif.ihit = 1'b1;
        step("sat_hold", E_RUN, 1'b0, 15);
        nRST = 1'b0;
        step("rst2", E_OFF, 1'b0, 0);
        nRST = 1'b1;

        pif.halt_me = 1'b1; pif.dREN_me = 1'b1;
        step("hm_miss", E_OFF, 1'b0, 0);
        step("hm_dwait", E_OFF, 1'b0, 1);
        pif.dhit = 1'b1;
        step("hm_hit", E_RUN, 1'b0, 2);
        pif.dhit = 1'b0; pif.dREN_me = 1'b0;
        step("hm_run", E_RUN, 1'b0, 2);
        pif.halt_me = 1'b0;
        step("drain1", E_HOLD, 1'b0, 2);
        pif.branch_taken_ex = 1'b1;
        step("drain2", E_HOLD, 1'b0, 2);
        set_idle();
        step("halted", E_OFF, 1'b1, 2);
        for (int i = 0; i < 100; i++) begin
            pif.ihit            = 1'($urandom_range(0, 1));
            pif.dhit            = 1'($urandom_range(0, 1));
            pif.branch_taken_ex = 1'($urandom_range(0, 1));
            pif.jump_de         = 1'($urandom_range(0, 1));
            pif.halt_me         = 1'($urandom_range(0, 1));
            step("halt_hold", E_OFF, 1'b1, 2);
        end

        nRST = 1'b0; set_idle();
        step("rst_halt", E_OFF, 1'b0, 0);
        nRST = 1'b1;
        step("restart", E_RUN, 1'b0, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
